sensor_conditioner: RTL and testbench

//  Front-end stage for the parking-lot occupancy logic. Sits between the raw

---
 rtl/sensor_cond_pkg.sv | 14 +
 rtl/sensor_conditioner_debounce_channel.sv | 95 +++++++++
 rtl/sensor_conditioner.sv | 66 ++++++
 tb/tb_sensor_conditioner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_cond_pkg.sv
// Shared types for the parking-lot sensor front end.
// Debounce FSM state encoding and glitch counter width.
package sensor_cond_pkg;

    typedef enum logic [1:0] {
        ST_LO,
        W_HI,
        ST_HI,
        W_LO
    } deb_state_t;

    localparam int GLITCH_W = 8;

endpackage

// File: rtl/sensor_conditioner_debounce_channel.sv
// One sensor bit: synchroniser chain, debounce FSM and window counter.
// Emits a registered level plus one-cycle rise/fall/glitch pulses.
module debounce_channel
    import sensor_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("debounce_channel: SYNC_STAGES and DEBOUNCE_CYCLES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    deb_state_t             state;
    logic [CW-1:0]          cnt;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync   <= '0;
            state  <= ST_LO;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], raw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
            unique case (state)
                ST_LO: begin
                    if (s) begin
                        state <= W_HI;
                        cnt   <= CW'(1);
                    end
                end
                W_HI: begin
                    if (!s) begin
                        state  <= ST_LO;
                        cnt    <= '0;
                        glitch <= 1'b1;
                    end else if (cnt == LAST) begin
                        state <= ST_HI;
                        cnt   <= '0;
                        level <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        state <= W_LO;
                        cnt   <= CW'(1);
                    end
                end
                W_LO: begin
                    if (s) begin
                        state  <= ST_HI;
                        cnt    <= '0;
                        glitch <= 1'b1;
                    end else if (cnt == LAST) begin
                        state <= ST_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front end: N_CH debounced channels plus optional glitch counter.
// Define SENSOR_GLITCH_CNT_EN to build the saturating GlitchCount counter.
module sensor_conditioner
    import sensor_cond_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [N_CH-1:0]     RawSensor,
    output logic [N_CH-1:0]     Sensor,
    output logic [N_CH-1:0]     Rise,
    output logic [N_CH-1:0]     Fall,
    output logic [GLITCH_W-1:0] GlitchCount
);

    logic [N_CH-1:0] glitch;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .raw   (RawSensor[i]),
            .level (Sensor[i]),
            .rise  (Rise[i]),
            .fall  (Fall[i]),
            .glitch(glitch[i])
        );
    end

`ifdef SENSOR_GLITCH_CNT_EN
    // Wide enough to hold count plus every channel glitching at once.
    localparam int SW = GLITCH_W + $clog2(N_CH + 1);
    localparam logic [SW-1:0] SAT = SW'((1 << GLITCH_W) - 1);

    logic [SW-1:0] sum;

    always_comb begin
        sum = SW'(GlitchCount);
        for (int i = 0; i < N_CH; i++) begin
            sum = sum + SW'(glitch[i]);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            GlitchCount <= '0;
        end else if (sum > SAT) begin
            GlitchCount <= SAT[GLITCH_W-1:0];
        end else begin
            GlitchCount <= sum[GLITCH_W-1:0];
        end
    end
`else
    logic unused_glitch;

    assign unused_glitch = ^glitch;
    assign GlitchCount   = '0;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner (default parameters).
// Cycle-level reference model plus table-driven and directed sequences.
module tb_sensor_conditioner;

    localparam int S = 2;
    localparam int D = 4;
    localparam int HLEN = 16;

    logic       Clk;
    logic       Rst_n;
    logic [1:0] RawSensor;
    logic [1:0] Sensor;
    logic [1:0] Rise;
    logic [1:0] Fall;
    logic [7:0] GlitchCount;

    int checks = 0;
    int errors = 0;

    sensor_conditioner dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .RawSensor  (RawSensor),
        .Sensor     (Sensor),
        .Rise       (Rise),
        .Fall       (Fall),
        .GlitchCount(GlitchCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

`ifdef SENSOR_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    // Reference model: history of raw samples per edge (index 0 = newest).
    // The FSM sees the sample taken S edges earlier; the level flips once
    // the last D seen samples all disagree with it.
    bit         hist[2][$];
    logic [1:0] m_level;
    logic [1:0] m_rise;
    logic [1:0] m_fall;
    int         m_gc;
    int         m_gpend;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            hist[c].delete();
            for (int j = 0; j < HLEN; j++) hist[c].push_back(1'b0);
        end
        m_level = 2'b00;
        m_rise  = 2'b00;
        m_fall  = 2'b00;
        m_gc    = 0;
        m_gpend = 0;
    endtask

    task automatic model_step(input logic [1:0] raw);
        bool_flip: begin end
        if (GC_EN) m_gc = (m_gc + m_gpend > 255) ? 255 : m_gc + m_gpend;
        m_gpend = 0;
        m_rise  = 2'b00;
        m_fall  = 2'b00;
        for (int c = 0; c < 2; c++) begin
            bit all_diff;
            hist[c].push_front(raw[c]);
            void'(hist[c].pop_back());
            all_diff = 1'b1;
            for (int j = 0; j < D; j++)
                if (hist[c][S+j] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
                if (m_level[c]) m_fall[c] = 1'b1;
                else m_rise[c] = 1'b1;
                m_level[c] = ~m_level[c];
            end else if (hist[c][S] == m_level[c] && hist[c][S+1] != m_level[c]) begin
                m_gpend++;
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        if (!Rst_n) model_reset();
        else model_step(RawSensor);
        #1;
        check("model_sensor", int'(Sensor), int'(m_level));
        check("model_rise", int'(Rise), int'(m_rise));
        check("model_fall", int'(Fall), int'(m_fall));
        check("model_gcount", int'(GlitchCount), m_gc);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        #1;
        model_reset();
        tick();
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic pulse_reset();
        #2;
        Rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_sensor", int'(Sensor), 0);
        check("rst_async_rise", int'(Rise), 0);
        check("rst_async_fall", int'(Fall), 0);
        check("rst_async_gcount", int'(GlitchCount), 0);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic measure_latency(input string name, input logic [1:0] want);
        int lat;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (Sensor == want) lat = c;
        end
        check(name, lat, S + D);
    endtask

    typedef struct {
        logic [1:0] raw;
        int         hold;
        logic [1:0] exp_sensor;
        logic [1:0] exp_rise;
        logic [1:0] exp_fall;
        int         exp_lat;
    } vec_t;

    vec_t car[5];

    initial begin
        logic [1:0] racc;
        logic [1:0] facc;
        logic [1:0] start;
        int         lat;
        int         rcnt;
        int         fbad;

        car[0] = '{2'b00, 8, 2'b00, 2'b00, 2'b00, 0};
        car[1] = '{2'b10, 8, 2'b10, 2'b10, 2'b00, 6};
        car[2] = '{2'b11, 8, 2'b11, 2'b01, 2'b00, 6};
        car[3] = '{2'b01, 8, 2'b01, 2'b00, 2'b10, 6};
        car[4] = '{2'b00, 8, 2'b00, 2'b00, 2'b01, 6};

        Rst_n     = 1'b0;
        RawSensor = 2'b11;
        model_reset();

        // Held in reset with both beams blocked: nothing moves.
        for (int i = 0; i < 5; i++) tick();
        check("reset_sensor", int'(Sensor), 0);
        check("reset_rise", int'(Rise), 0);
        check("reset_fall", int'(Fall), 0);
        check("reset_gcount", int'(GlitchCount), 0);
        RawSensor = 2'b00;
        Rst_n     = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // Outer beam blocked and held.
        do_reset();
        RawSensor = 2'b10;
        lat  = 0;
        rcnt = 0;
        fbad = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (Sensor[1] && lat == 0) lat = c;
            if (Rise == 2'b10) rcnt++;
            if (Fall != 2'b00) fbad++;
        end
        check("rise_latency", lat, 6);
        check("rise_pulse_cycles", rcnt, 1);
        check("no_fall_on_rise", fbad, 0);
        check("held_sensor", int'(Sensor), 2);

        // Short pulse on the inner beam is rejected.
        do_reset();
        RawSensor = 2'b01;
        tick();
        tick();
        RawSensor = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        check("short_pulse_sensor", int'(Sensor), 0);
        check("short_pulse_gcount", int'(GlitchCount), GC_EN ? 1 : 0);

        // Both channels glitch on the same edge.
        do_reset();
        RawSensor = 2'b11;
        tick();
        tick();
        RawSensor = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        check("dual_glitch_gcount", int'(GlitchCount), GC_EN ? 2 : 0);

        // Car entry sequence from the table.
        do_reset();
        for (int v = 0; v < 5; v++) begin
            RawSensor = car[v].raw;
            start = Sensor;
            racc = 2'b00;
            facc = 2'b00;
            lat  = 0;
            for (int c = 1; c <= car[v].hold; c++) begin
                tick();
                racc |= Rise;
                facc |= Fall;
                if (lat == 0 && Sensor != start) lat = c;
            end
            check($sformatf("car%0d_sensor", v), int'(Sensor), int'(car[v].exp_sensor));
            check($sformatf("car%0d_rise", v), int'(racc), int'(car[v].exp_rise));
            check($sformatf("car%0d_fall", v), int'(facc), int'(car[v].exp_fall));
            check($sformatf("car%0d_latency", v), lat, car[v].exp_lat);
        end

        // Async reset with Sensor high, then mid-window in W_HI.
        do_reset();
        RawSensor = 2'b11;
        for (int i = 0; i < 8; i++) tick();
        check("pre_reset_sensor", int'(Sensor), 3);
        pulse_reset();
        measure_latency("relatch_latency", 2'b11);
        pulse_reset();
        tick();
        tick();
        tick();
        pulse_reset();
        measure_latency("whi_abort_latency", 2'b11);

        // Randomised segments against the reference model.
        do_reset();
        for (int seg = 0; seg < 120; seg++) begin
            int hold;
            RawSensor = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 9);
            for (int c = 0; c < hold; c++) tick();
        end

        // Flood channel 1 with glitches to hit saturation.
        do_reset();
        for (int g = 0; g < 300; g++) begin
            RawSensor = 2'b10;
            tick();
            tick();
            RawSensor = 2'b00;
            tick();
            tick();
            tick();
        end
        for (int i = 0; i < 4; i++) tick();
        check("sat_gcount", int'(GlitchCount), GC_EN ? 255 : 0);
        RawSensor = 2'b10;
        tick();
        tick();
        RawSensor = 2'b00;
        for (int i = 0; i < 6; i++) tick();
        check("sat_hold_gcount", int'(GlitchCount), GC_EN ? 255 : 0);
        check("sat_sensor", int'(Sensor), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
